// File: rtl/space_pkg.sv
// Shared encodings and default constants for the game sequencer and its siblings.
package space_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_WIN   = 2'b10,
    ST_OVER  = 2'b11
  } game_st_e;

  localparam logic [7:0] LED_OFF    = 8'h00;
  localparam logic [7:0] LED_WIN    = 8'hFF;
  localparam logic [7:0] LED_OVER_A = 8'hAA;
  localparam logic [7:0] LED_OVER_B = 8'h55;

  localparam int unsigned DEF_N_OBS        = 8;
  localparam int unsigned DEF_START_FRAMES = 2;
  localparam int unsigned DEF_HOLD_FRAMES  = 180;
  localparam int unsigned DEF_LOCK_FRAMES  = 30;
  localparam int unsigned DEF_BLINK_LOG2   = 4;

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the obstacle field / buttons and the game sequencer.
interface game_ctrl_if #(
  parameter int unsigned N_OBS = 8
);
  localparam int unsigned SCORE_W = $clog2(N_OBS + 1);

  logic               i_frame_tick;
  logic [N_OBS-1:0]   i_obs_state;
  logic [N_OBS-1:0]   i_crossed;
  logic               i_fire;
  logic [1:0]         o_game_st;
  logic               o_gamewin;
  logic               o_gameover;
  logic               o_soft_reset;
  logic [SCORE_W-1:0] o_score;
  logic [7:0]         o_leds;

  modport master (
    output i_frame_tick, i_obs_state, i_crossed, i_fire,
    input  o_game_st, o_gamewin, o_gameover, o_soft_reset, o_score, o_leds
  );

  modport slave (
    input  i_frame_tick, i_obs_state, i_crossed, i_fire,
    output o_game_st, o_gamewin, o_gameover, o_soft_reset, o_score, o_leds
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous button, followed by a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_q;
  logic r_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_q <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_q <= r_sync;
      r_rise   <= r_sync & ~r_sync_q;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/game_ctrl.sv
// Restartable play/win/over sequencer; all outputs are registered alongside the state.
module game_ctrl
  import space_pkg::*;
#(
  parameter int unsigned N_OBS        = DEF_N_OBS,
  parameter int unsigned START_FRAMES = DEF_START_FRAMES,
  parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES,
  parameter int unsigned LOCK_FRAMES  = DEF_LOCK_FRAMES,
  parameter int unsigned BLINK_LOG2   = DEF_BLINK_LOG2
) (
  input logic        clk,
  input logic        reset,
  game_ctrl_if.slave bus
);

  localparam int unsigned SCORE_W    = $clog2(N_OBS + 1);
  localparam int unsigned LED_W      = (N_OBS < 8) ? N_OBS : 8;
  localparam logic [7:0]  START_LAST = 8'(START_FRAMES - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  LOCK_MIN   = 8'(LOCK_FRAMES);

  game_st_e           r_state, w_state_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt, w_pop;
  logic [7:0]         r_leds, w_leds_nxt;
  logic               r_win, r_over, r_soft;
  logic               w_fire_rise;

  sync_edge u_fire_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.i_fire),
    .o_rise  (w_fire_rise)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_START: if (bus.i_frame_tick && r_cnt == START_LAST) w_state_nxt = ST_PLAY;
      ST_PLAY: begin
        // A breach outranks a cleared field in the same cycle.
        if (|bus.i_crossed)              w_state_nxt = ST_OVER;
        else if (bus.i_obs_state == '0)  w_state_nxt = ST_WIN;
      end
      ST_WIN, ST_OVER: begin
        if ((bus.i_frame_tick && r_cnt == HOLD_LAST) || (w_fire_rise && r_cnt >= LOCK_MIN))
          w_state_nxt = ST_START;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_OBS; i++) w_pop = w_pop + SCORE_W'(~bus.i_obs_state[i]);

    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state)                  w_cnt_nxt = '0;
    else if (bus.i_frame_tick && r_cnt != 8'hFF) w_cnt_nxt = r_cnt + 8'd1;

    w_score_nxt = r_score;
    if (r_state == ST_PLAY)           w_score_nxt = w_pop;
    else if (w_state_nxt == ST_START) w_score_nxt = '0;

    w_leds_nxt = LED_OFF;
    unique case (w_state_nxt)
      ST_START: w_leds_nxt = LED_OFF;
      ST_PLAY: begin
        if (r_state == ST_PLAY)
          for (int i = 0; i < LED_W; i++) w_leds_nxt[i] = ~bus.i_obs_state[i];
      end
      ST_WIN:  w_leds_nxt = LED_WIN;
      ST_OVER: w_leds_nxt = w_cnt_nxt[BLINK_LOG2] ? LED_OVER_B : LED_OVER_A;
      default: w_leds_nxt = LED_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_START;
      r_cnt   <= '0;
      r_score <= '0;
      r_leds  <= LED_OFF;
      r_win   <= 1'b0;
      r_over  <= 1'b0;
      r_soft  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_score <= w_score_nxt;
      r_leds  <= w_leds_nxt;
      r_win   <= (w_state_nxt == ST_WIN);
      r_over  <= (w_state_nxt == ST_OVER);
      r_soft  <= (w_state_nxt == ST_START);
    end
  end

  assign bus.o_game_st    = r_state;
  assign bus.o_gamewin    = r_win;
  assign bus.o_gameover   = r_over;
  assign bus.o_soft_reset = r_soft;
  assign bus.o_score      = r_score;
  assign bus.o_leds       = r_leds;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start-up, play, win hold, over lock-out/blink, mid-game reset.
module tb_game_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  game_ctrl_if #(.N_OBS(8)) bus ();

  game_ctrl #(.N_OBS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [7:0] play_obs   [7] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
  logic [7:0] play_leds  [7] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
  logic [3:0] play_score [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame = 99 idle clocks followed by a single-clock frame_tick.
  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      step(99);
      bus.i_frame_tick = 1'b1;
      step(1);
      bus.i_frame_tick = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_frame_tick = 1'b0;
    bus.i_obs_state  = 8'hFF;
    bus.i_crossed    = 8'h00;
    bus.i_fire       = 1'b0;

    step(3);
    check("rst_st",    32'(bus.o_game_st), 32'h0);
    check("rst_soft",  32'(bus.o_soft_reset), 32'h1);
    check("rst_win",   32'(bus.o_gamewin), 32'h0);
    check("rst_over",  32'(bus.o_gameover), 32'h0);
    check("rst_score", 32'(bus.o_score), 32'h0);
    check("rst_leds",  32'(bus.o_leds), 32'h0);
    reset = 1'b0;

    frames(1);
    check("start_t1_st",   32'(bus.o_game_st), 32'h0);
    check("start_t1_soft", 32'(bus.o_soft_reset), 32'h1);
    frames(1);
    check("start_t2_st",   32'(bus.o_game_st), 32'h1);
    check("start_t2_soft", 32'(bus.o_soft_reset), 32'h0);
    check("play_entry_score", 32'(bus.o_score), 32'h0);

    for (int k = 0; k < 7; k++) begin
      bus.i_obs_state = play_obs[k];
      step(1);
      check($sformatf("play_score_%0d", k), 32'(bus.o_score), 32'(play_score[k]));
      check($sformatf("play_leds_%0d", k),  32'(bus.o_leds),  32'(play_leds[k]));
      frames(1);
    end
    bus.i_obs_state = 8'h00;
    step(1);
    check("win_st",    32'(bus.o_game_st), 32'h2);
    check("win_flag",  32'(bus.o_gamewin), 32'h1);
    check("win_over",  32'(bus.o_gameover), 32'h0);
    check("win_leds",  32'(bus.o_leds), 32'hFF);
    check("win_score", 32'(bus.o_score), 32'h8);

    frames(179);
    check("win_hold_179", 32'(bus.o_game_st), 32'h2);
    frames(1);
    check("win_hold_180_st",   32'(bus.o_game_st), 32'h0);
    check("win_hold_180_soft", 32'(bus.o_soft_reset), 32'h1);
    check("win_hold_180_win",  32'(bus.o_gamewin), 32'h0);
    check("start_leds",        32'(bus.o_leds), 32'h0);

    bus.i_obs_state = 8'hFF;
    frames(2);
    check("replay1_st",    32'(bus.o_game_st), 32'h1);
    check("replay1_score", 32'(bus.o_score), 32'h0);

    bus.i_crossed   = 8'h04;
    bus.i_obs_state = 8'h00;
    step(1);
    check("over_st",    32'(bus.o_game_st), 32'h3);
    check("over_flag",  32'(bus.o_gameover), 32'h1);
    check("over_win",   32'(bus.o_gamewin), 32'h0);
    check("over_leds0", 32'(bus.o_leds), 32'hAA);
    bus.i_crossed   = 8'h00;
    bus.i_obs_state = 8'h0F;

    frames(10);
    check("over_score_frozen", 32'(bus.o_score), 32'h8);
    bus.i_fire = 1'b1;
    step(5);
    bus.i_fire = 1'b0;
    step(3);
    check("over_fire_locked", 32'(bus.o_game_st), 32'h3);

    frames(5);
    check("over_blink_15", 32'(bus.o_leds), 32'hAA);
    frames(1);
    check("over_blink_16", 32'(bus.o_leds), 32'h55);
    frames(16);
    check("over_blink_32", 32'(bus.o_leds), 32'hAA);
    frames(8);

    bus.i_fire = 1'b1;
    step(3);
    check("over_fire_wait", 32'(bus.o_game_st), 32'h3);
    step(1);
    check("over_fire_start", 32'(bus.o_game_st), 32'h0);
    check("over_fire_soft",  32'(bus.o_soft_reset), 32'h1);
    bus.i_fire      = 1'b0;
    bus.i_obs_state = 8'hFF;

    frames(2);
    check("replay2_st",    32'(bus.o_game_st), 32'h1);
    check("replay2_score", 32'(bus.o_score), 32'h0);

    bus.i_obs_state = 8'hE0;
    step(1);
    check("mid_score5", 32'(bus.o_score), 32'h5);
    reset = 1'b1;
    #2;
    check("mid_rst_st",    32'(bus.o_game_st), 32'h0);
    check("mid_rst_score", 32'(bus.o_score), 32'h0);
    check("mid_rst_soft",  32'(bus.o_soft_reset), 32'h1);
    check("mid_rst_leds",  32'(bus.o_leds), 32'h0);
    step(2);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
